// File: rtl/axis_pkt_gen.sv
// AXI-Stream test-packet generator: bursts of counter-pattern packets with sweeping tail tkeep.
// Optional PRBS-31 payload when AXIS_PKT_GEN_PRBS_EN is defined.
module axis_pkt_gen #(
  parameter int unsigned P_DATA_WIDTH = 64,
  parameter int unsigned P_USER_WIDTH = 32,
  parameter int unsigned P_INIT_WAIT  = 63
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic [15:0]               i_pkt_beats,
  input  logic [15:0]               i_pkt_num,
  input  logic [7:0]                i_gap,
`ifdef AXIS_PKT_GEN_PRBS_EN
  input  logic                      i_prbs_mode,
`endif
  output logic [P_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [P_USER_WIDTH-1:0]   m_axis_tuser,
  output logic [P_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      s_axis_tready,
  output logic                      o_busy,
  output logic [31:0]               o_pkt_cnt
);

  localparam int unsigned BYTES  = P_DATA_WIDTH / 8;
  localparam int unsigned LANES  = P_DATA_WIDTH / 16;
  localparam int unsigned SEQ_W  = $clog2(BYTES + 1);
  localparam int unsigned CALC_W = 24;

  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_SEND, S_GAP} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             wait_q, wait_d;
  logic [15:0]             beats_q, beats_d, num_q, num_d;
  logic [7:0]              gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [15:0]             burst_q, burst_d, beat_q, beat_d;
  logic [SEQ_W-1:0]        seq_q, seq_d;
  logic [P_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [P_USER_WIDTH-1:0] tuser_q, tuser_d;
  logic [BYTES-1:0]        tkeep_q, tkeep_d;
  logic                    tlast_q, tlast_d, tvalid_q, tvalid_d, busy_q, busy_d;
  logic [31:0]             pkt_cnt_q, pkt_cnt_d;

  logic [15:0]             beats_eff_c;
  logic [SEQ_W-1:0]        valid_bytes_c;
  logic [BYTES-1:0]        tail_keep_c;
  logic                    hs_c;
  logic [P_DATA_WIDTH-1:0] beat_data_c;

  assign beats_eff_c   = (beats_q == 16'd0) ? 16'd1 : beats_q;
  assign valid_bytes_c = seq_q + SEQ_W'(1);
  // MSB-aligned tail: top valid_bytes_c bits set
  assign tail_keep_c   = ~({BYTES{1'b1}} >> valid_bytes_c);
  assign hs_c          = tvalid_q & s_axis_tready;

`ifdef AXIS_PKT_GEN_PRBS_EN
  logic [30:0]             prbs_q, prbs_d, prbs_next_c, lfsr_c;
  logic                    prbs_mode_q, prbs_mode_d;
  logic [P_DATA_WIDTH-1:0] prbs_data_c;

  // PRBS-31 (x^31 + x^28 + 1), P_DATA_WIDTH bits per beat
  always_comb begin
    lfsr_c      = prbs_q;
    prbs_data_c = '0;
    for (int i = 0; i < int'(P_DATA_WIDTH); i++) begin
      prbs_data_c[i] = lfsr_c[30] ^ lfsr_c[27];
      lfsr_c         = {lfsr_c[29:0], prbs_data_c[i]};
    end
    prbs_next_c = lfsr_c;
  end

  assign beat_data_c = prbs_mode_q ? prbs_data_c : {LANES{16'(beat_q + 16'd1)}};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prbs_q      <= '1;
      prbs_mode_q <= 1'b0;
    end else begin
      prbs_q      <= prbs_d;
      prbs_mode_q <= prbs_mode_d;
    end
  end
`else
  assign beat_data_c = {LANES{16'(beat_q + 16'd1)}};
`endif

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    beats_d   = beats_q;
    num_d     = num_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    seq_d     = seq_q;
    tdata_d   = tdata_q;
    tuser_d   = tuser_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q;
    pkt_cnt_d = pkt_cnt_q;
`ifdef AXIS_PKT_GEN_PRBS_EN
    prbs_d      = prbs_q;
    prbs_mode_d = prbs_mode_q;
`endif
    case (state_q)
      S_WAIT: begin
        wait_d = wait_q + 32'd1;
        if ((wait_q + 32'd1) >= 32'(P_INIT_WAIT)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (i_start) begin
          beats_d = i_pkt_beats;
          num_d   = i_pkt_num;
          gap_d   = i_gap;
          burst_d = '0;
          seq_d   = '0;
          beat_d  = '0;
          state_d = S_SEND;
`ifdef AXIS_PKT_GEN_PRBS_EN
          prbs_d      = '1;
          prbs_mode_d = i_prbs_mode;
`endif
        end
      end
      S_SEND: begin
        if (hs_c && tlast_q) begin
          tvalid_d  = 1'b0;
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          burst_d   = burst_q + 16'd1;
          seq_d     = (seq_q == SEQ_W'(BYTES - 1)) ? '0 : seq_q + SEQ_W'(1);
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else if ((!tvalid_q || s_axis_tready) && (beat_q < beats_eff_c)) begin
          // present the next beat; registers only move when the sink took the previous one
          tvalid_d = 1'b1;
          tdata_d  = beat_data_c;
          tlast_d  = (beat_q == beats_eff_c - 16'd1);
          tkeep_d  = (beat_q == beats_eff_c - 16'd1) ? tail_keep_c : '1;
          tuser_d  = P_USER_WIDTH'(CALC_W'(BYTES) * CALC_W'(beats_eff_c - 16'd1)
                                   + CALC_W'(valid_bytes_c));
          beat_d   = beat_q + 16'd1;
`ifdef AXIS_PKT_GEN_PRBS_EN
          if (prbs_mode_q) prbs_d = prbs_next_c;
`endif
        end else if (hs_c) begin
          tvalid_d = 1'b0;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + 8'd1;
        if (({1'b0, gap_cnt_q} + 9'd1) >= {1'b0, gap_q}) begin
          beat_d = '0;
          if (i_stop || ((num_q != 16'd0) && (burst_q == num_q))) state_d = S_IDLE;
          else                                                   state_d = S_SEND;
        end
      end
      default: state_d = S_WAIT;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_WAIT;
      wait_q    <= '0;
      beats_q   <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      seq_q     <= '0;
      tdata_q   <= '0;
      tuser_q   <= '0;
      tkeep_q   <= '1;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      beats_q   <= beats_d;
      num_q     <= num_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      seq_q     <= seq_d;
      tdata_q   <= tdata_d;
      tuser_q   <= tuser_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
      busy_q    <= busy_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign o_busy        = busy_q;
  assign o_pkt_cnt     = pkt_cnt_q;

endmodule
